// File: rtl/byte_serial_adder_if.sv
// Valid/ready bundle for the byte-serial adder: operand byte pairs in, sum bytes out.
interface byte_serial_adder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_last;
  logic       out_cout;
  logic       out_ovf;
  logic       out_err;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, out_err
  );
endinterface

// File: rtl/byte_serial_adder.sv
// Multi-byte adder on one 8-bit adder: LSB-first byte pairs, carry chained in a flop,
// registered single-entry output stage.
//   state | meaning
//   IDLE  | first byte of a word expected; carry and counter are zero
//   BUSY  | inside a word; carry and counter hold the running state
module byte_serial_adder #(
  parameter int MAX_BYTES = 4,
  parameter int CNT_W     = 8
) (
  input logic               clk,
  input logic               rst_n,
  byte_serial_adder_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BYTES - 1);

  state_t           state_q, state_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             out_valid_q;
  logic [7:0]       out_sum_q;
  logic             out_last_q, out_cout_q, out_ovf_q, out_err_q;

  logic             accept, consume, term, ovf;
  logic [8:0]       add;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept  = bus.in_valid && bus.in_ready;
  assign consume = out_valid_q && bus.out_ready;
  assign add     = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {8'b0, carry_q};
  assign term    = bus.in_last || (cnt_q == LAST_IDX);
  assign ovf     = (bus.in_a[7] == bus.in_b[7]) && (add[7] != bus.in_a[7]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, BUSY: begin
        if (accept) begin
          if (term) begin
            state_d = IDLE;
            carry_d = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = BUSY;
            carry_d = add[8];
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flags only qualify the final byte of a word; intermediate bytes report zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= 8'h00;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= add[7:0];
      out_last_q  <= term;
      out_cout_q  <= term && add[8];
      out_ovf_q   <= term && ovf;
      out_err_q   <= term && !bus.in_last;
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Scoreboard bench for byte_serial_adder: directed byte pairs with hand-computed sums.
module tb_byte_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       last;
    logic       cout;
    logic       ovf;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n_push;
  int   n_pop;
  exp_t sb[$];

  byte_serial_adder_if bus ();

  byte_serial_adder #(.MAX_BYTES(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed output is compared with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 8'h01, 8'h00);
        end else begin
          e = sb.pop_front();
          n_pop++;
          chk("out_sum",  bus.out_sum, e.sum);
          chk("out_last", {7'b0, bus.out_last}, {7'b0, e.last});
          chk("out_cout", {7'b0, bus.out_cout}, {7'b0, e.cout});
          chk("out_ovf",  {7'b0, bus.out_ovf},  {7'b0, e.ovf});
          chk("out_err",  {7'b0, bus.out_err},  {7'b0, e.err});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last,
                      input logic [7:0] es, input logic el, input logic ec,
                      input logic eo, input logic ee);
    bit got;
    int waited;
    exp_t e;
    got = 0;
    waited = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    while (!got && waited < 50) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1;
        e.sum = es; e.last = el; e.cout = ec; e.ovf = eo; e.err = ee;
        sb.push_back(e);
        n_push++;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    if (!got) chk("accept_timeout", 8'h00, 8'h01);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; n_push = 0; n_pop = 0;
    bus.in_valid = 1'b0; bus.in_a = 8'h00; bus.in_b = 8'h00; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    chk("rst_out_valid", {7'b0, bus.out_valid}, 8'h00);
    chk("rst_in_ready",  {7'b0, bus.in_ready},  8'h01);
    chk("rst_out_sum",   bus.out_sum, 8'h00);
    chk("rst_flags", {4'b0, bus.out_last, bus.out_cout, bus.out_ovf, bus.out_err}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // single byte with signed overflow
    send(8'h7F, 8'h01, 1'b1, 8'h80, 1, 0, 1, 0);
    idle(2);

    // 0x00FFFFFF + 0x00000001 back-to-back
    send(8'hFF, 8'h01, 1'b0, 8'h00, 0, 0, 0, 0);
    send(8'hFF, 8'h00, 1'b0, 8'h00, 0, 0, 0, 0);
    send(8'hFF, 8'h00, 1'b0, 8'h00, 0, 0, 0, 0);
    send(8'h00, 8'h00, 1'b1, 8'h01, 1, 0, 0, 0);
    idle(2);

    // word carry-out, then carry must be clear for the next word
    send(8'hFF, 8'h01, 1'b0, 8'h00, 0, 0, 0, 0);
    send(8'hFF, 8'h00, 1'b1, 8'h00, 1, 1, 0, 0);
    send(8'h01, 8'h01, 1'b1, 8'h02, 1, 0, 0, 0);
    idle(2);

    // backpressure: one byte pending, a second held off for 3 cycles
    bus.out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b1, 8'h33, 1, 0, 0, 0);
    bus.in_a = 8'h44; bus.in_b = 8'h55; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready",  {7'b0, bus.in_ready},  8'h00);
      chk("bp_out_valid", {7'b0, bus.out_valid}, 8'h01);
      chk("bp_out_sum",   bus.out_sum, 8'h33);
      chk("bp_out_last",  {7'b0, bus.out_last},  8'h01);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(8'h44, 8'h55, 1'b1, 8'h99, 1, 0, 1, 0);
    chk("bp_reload_valid", {7'b0, bus.out_valid}, 8'h01);
    chk("bp_reload_sum",   bus.out_sum, 8'h99);
    idle(2);

    // forced termination at 4 bytes, 5th byte opens a new word
    send(8'hFF, 8'h00, 1'b0, 8'hFF, 0, 0, 0, 0);
    send(8'hFF, 8'h00, 1'b0, 8'hFF, 0, 0, 0, 0);
    send(8'hFF, 8'h00, 1'b0, 8'hFF, 0, 0, 0, 0);
    send(8'hFF, 8'h00, 1'b0, 8'hFF, 1, 0, 0, 1);
    send(8'hFF, 8'h00, 1'b0, 8'hFF, 0, 0, 0, 0);
    send(8'h01, 8'h00, 1'b1, 8'h01, 1, 0, 0, 0);
    idle(2);

    // forced termination with a live carry; carry must not cross into the next word
    send(8'hFF, 8'h01, 1'b0, 8'h00, 0, 0, 0, 0);
    send(8'hFF, 8'h01, 1'b0, 8'h01, 0, 0, 0, 0);
    send(8'hFF, 8'h01, 1'b0, 8'h01, 0, 0, 0, 0);
    send(8'hFF, 8'h01, 1'b0, 8'h01, 1, 1, 0, 1);
    send(8'h00, 8'h00, 1'b1, 8'h00, 1, 0, 0, 0);
    idle(2);

    // reset mid-word with carry pending; the unconsumed byte is discarded
    send(8'hFF, 8'h01, 1'b0, 8'h00, 0, 0, 0, 0);
    send(8'hFF, 8'h00, 1'b0, 8'h00, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {7'b0, bus.out_valid}, 8'h00);
    if (sb.size() > 0) begin
      void'(sb.pop_back());
      n_push--;
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send(8'h10, 8'h20, 1'b1, 8'h30, 1, 0, 0, 0);
    idle(4);

    chk("sb_empty", 8'(sb.size()), 8'h00);
    chk("pop_count", 8'(n_pop), 8'(n_push));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
